pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 4-stage in-order pipeline (fetch, decode, execute, memory). Consumes decode-stage operand-use and store information, the execute-stage destination and load flag, memory handshake status and the execute-stage branch redirect. Produces per-stage stall, bubble and flush controls. Tracks multi-cycle memory waits, deferred redirects and a memory-timeout hard stop.

---
 rtl/pipeline_hazard_controller.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_hazard_controller: stall/bubble/flush sequencer for a 4-stage pipe.
// Optional perf counters: HAZARD_PERF_COUNTER_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      decode_valid,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs2,
  input  logic                      decode_use_rs1,
  input  logic                      decode_use_rs2,
  input  logic                      decode_is_store,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      branch_taken,
  output logic                      fetch_stall,
  output logic                      decode_stall,
  output logic                      ex_stall,
  output logic                      mem_stall,
  output logic                      ex_bubble,
  output logic                      fetch_flush,
  output logic                      decode_flush,
  output logic                      mem_timeout_err
`ifdef HAZARD_PERF_COUNTER_EN
  ,
  output logic [CNT_WIDTH-1:0]      perf_load_use_cnt,
  output logic [CNT_WIDTH-1:0]      perf_mem_wait_cnt,
  output logic [CNT_WIDTH-1:0]      perf_flush_cnt
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t              state;
  logic                pending_flush;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_next;
  logic                mem_busy;
  logic                load_use;

  assign mem_busy  = mem_req & ~mem_ready;
  assign wait_next = wait_cnt + WAIT_W'(1);
  assign load_use  = decode_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                     ((decode_use_rs1 & (decode_rs1 == ex_rd)) |
                      ((decode_use_rs2 | decode_is_store) & (decode_rs2 == ex_rd)));

  // Outputs are gated by rst so the whole block is quiet while held in reset.
  always_comb begin
    fetch_stall     = 1'b0;
    decode_stall    = 1'b0;
    ex_stall        = 1'b0;
    mem_stall       = 1'b0;
    ex_bubble       = 1'b0;
    fetch_flush     = 1'b0;
    decode_flush    = 1'b0;
    mem_timeout_err = 1'b0;
    if (rst) begin
      case (state)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_busy) begin
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            ex_stall     = 1'b1;
            mem_stall    = 1'b1;
          end else if (branch_taken || (state == ST_MEM_WAIT && pending_flush)) begin
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
          end else if (load_use) begin
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            ex_bubble    = 1'b1;
          end
        end
        ST_ERROR: begin
          fetch_stall     = 1'b1;
          decode_stall    = 1'b1;
          ex_stall        = 1'b1;
          mem_stall       = 1'b1;
          mem_timeout_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_RUN;
      pending_flush <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_busy) begin
            state         <= ST_MEM_WAIT;
            wait_cnt      <= WAIT_W'(1);
            pending_flush <= branch_taken;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_busy) begin
            pending_flush <= pending_flush | branch_taken;
            // wait_next never exceeds MEM_TIMEOUT: reaching it leaves this state.
            wait_cnt      <= wait_next;
            if (wait_next == TIMEOUT_VAL) state <= ST_ERROR;
          end else begin
            state         <= ST_RUN;
            pending_flush <= 1'b0;
            wait_cnt      <= '0;
          end
        end
        ST_ERROR: ;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_load_use_cnt <= '0;
      perf_mem_wait_cnt <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (ex_bubble && perf_load_use_cnt != '1) perf_load_use_cnt <= perf_load_use_cnt + 1'b1;
      if (mem_stall && perf_mem_wait_cnt != '1) perf_mem_wait_cnt <= perf_mem_wait_cnt + 1'b1;
      if (fetch_flush && perf_flush_cnt != '1)  perf_flush_cnt    <= perf_flush_cnt + 1'b1;
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// Scoreboard bench for pipeline_hazard_controller; a second instance with
// MEM_TIMEOUT=4 covers the timeout path.
module tb_pipeline_hazard_controller;

  localparam int RW = 5;
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] ALLST = 8'b1111_0000;
  localparam logic [7:0] BUB   = 8'b1100_1000;
  localparam logic [7:0] FL    = 8'b0000_0110;
  localparam logic [7:0] ERR   = 8'b1111_0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic decode_valid = 0, decode_use_rs1 = 0, decode_use_rs2 = 0, decode_is_store = 0;
  logic [RW-1:0] decode_rs1 = '0, decode_rs2 = '0, ex_rd = '0;
  logic ex_valid = 0, ex_is_load = 0, mem_req = 0, mem_ready = 0, branch_taken = 0;

  logic [7:0] out_a, out_b;
  logic       sel_to = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int vectors = 0;
  int miscompares = 0;

`ifdef HAZARD_PERF_COUNTER_EN
  logic [31:0] plu_a, pmw_a, pfl_a, plu_b, pmw_b, pfl_b;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .decode_valid(decode_valid), .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
    .decode_use_rs1(decode_use_rs1), .decode_use_rs2(decode_use_rs2),
    .decode_is_store(decode_is_store), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .fetch_stall(out_a[7]), .decode_stall(out_a[6]), .ex_stall(out_a[5]),
    .mem_stall(out_a[4]), .ex_bubble(out_a[3]), .fetch_flush(out_a[2]),
    .decode_flush(out_a[1]), .mem_timeout_err(out_a[0])
`ifdef HAZARD_PERF_COUNTER_EN
    , .perf_load_use_cnt(plu_a), .perf_mem_wait_cnt(pmw_a), .perf_flush_cnt(pfl_a)
`endif
  );

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut_to (
    .clk(clk), .rst(rst),
    .decode_valid(decode_valid), .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
    .decode_use_rs1(decode_use_rs1), .decode_use_rs2(decode_use_rs2),
    .decode_is_store(decode_is_store), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .fetch_stall(out_b[7]), .decode_stall(out_b[6]), .ex_stall(out_b[5]),
    .mem_stall(out_b[4]), .ex_bubble(out_b[3]), .fetch_flush(out_b[2]),
    .decode_flush(out_b[1]), .mem_timeout_err(out_b[0])
`ifdef HAZARD_PERF_COUNTER_EN
    , .perf_load_use_cnt(plu_b), .perf_mem_wait_cnt(pmw_b), .perf_flush_cnt(pfl_b)
`endif
  );

  // One cycle: record the expectation, sample the selected DUT mid-cycle.
  task automatic tick(input logic [7:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back(sel_to ? out_b : out_a);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    decode_valid = 0; decode_use_rs1 = 0; decode_use_rs2 = 0; decode_is_store = 0;
    decode_rs1 = '0; decode_rs2 = '0; ex_rd = '0;
    ex_valid = 0; ex_is_load = 0; mem_req = 0; mem_ready = 0; branch_taken = 0;
  endtask

  task automatic set_load_use(input logic [RW-1:0] rd, input logic [RW-1:0] rs1);
    decode_valid = 1; decode_use_rs1 = 1; decode_rs1 = rs1;
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    logic [7:0] e, o;
    int n = 0;
    rst = 0;
    set_load_use(5'd5, 5'd5);
    mem_req = 1; branch_taken = 1;
    tick(NONE);
    mem_req = 0;
    tick(NONE);
    rst = 1;
    clear_inputs();
    tick(NONE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset[%0d]: got %b want %b", n, o, e); end
      n++;
    end
  endtask

  task automatic test_load_use();
    logic [7:0] e, o;
    int n = 0;
    set_load_use(5'd5, 5'd5);
    tick(BUB);
    ex_is_load = 0;
    tick(NONE);
    set_load_use(5'd0, 5'd0);
    tick(NONE);
    set_load_use(5'd5, 5'd5);
    decode_use_rs1 = 0;
    tick(NONE);
    decode_use_rs2 = 1; decode_rs2 = 5'd5;
    tick(BUB);
    ex_valid = 0;
    tick(NONE);
    clear_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL load_use[%0d]: got %b want %b", n, o, e); end
      n++;
    end
  endtask

  task automatic test_store();
    logic [7:0] e, o;
    int n = 0;
    set_load_use(5'd7, 5'd3);
    decode_is_store = 1; decode_use_rs2 = 0; decode_rs2 = 5'd7;
    tick(BUB);
    ex_is_load = 0;
    tick(NONE);
    ex_is_load = 1; decode_is_store = 0;
    tick(NONE);
    clear_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL store[%0d]: got %b want %b", n, o, e); end
      n++;
    end
  endtask

  task automatic test_mem_wait();
    logic [7:0] e, o;
    int n = 0;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) tick(ALLST);
    mem_ready = 1;
    tick(NONE);
    mem_req = 0; mem_ready = 0;
    tick(NONE);
    set_load_use(5'd9, 5'd9);
    tick(BUB);
    clear_inputs();
    mem_req = 1;
    tick(ALLST);
    mem_ready = 1;
    set_load_use(5'd9, 5'd9);
    tick(BUB);
    clear_inputs();
    tick(NONE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mem_wait[%0d]: got %b want %b", n, o, e); end
      n++;
    end
  endtask

  task automatic test_deferred_redirect();
    logic [7:0] e, o;
    int n = 0;
    mem_req = 1;
    tick(ALLST);
    branch_taken = 1;
    for (int i = 0; i < 3; i++) tick(ALLST);
    mem_ready = 1;
    tick(FL);
    clear_inputs();
    tick(NONE);
    mem_req = 1;
    tick(ALLST);
    branch_taken = 1;
    tick(ALLST);
    branch_taken = 0;
    tick(ALLST);
    mem_ready = 1;
    set_load_use(5'd4, 5'd4);
    tick(FL);
    clear_inputs();
    tick(NONE);
    tick(NONE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL deferred[%0d]: got %b want %b", n, o, e); end
      n++;
    end
  endtask

  task automatic test_branch_load_use();
    logic [7:0] e, o;
    int n = 0;
    do_reset();
    set_load_use(5'd6, 5'd6);
    branch_taken = 1;
    tick(FL);
    clear_inputs();
    tick(NONE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL branch_lu[%0d]: got %b want %b", n, o, e); end
      n++;
    end
`ifdef HAZARD_PERF_COUNTER_EN
    vectors++;
    if (pfl_a !== 32'd1) begin miscompares++; $display("FAIL perf_flush: got %0d want 1", pfl_a); end
    vectors++;
    if (plu_a !== 32'd0) begin miscompares++; $display("FAIL perf_load_use: got %0d want 0", plu_a); end
`endif
  endtask

  task automatic test_timeout();
    logic [7:0] e, o;
    int n = 0;
    sel_to = 1;
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) tick(ALLST);
    tick(ERR);
    tick(ERR);
    mem_ready = 1;
    tick(ERR);
    tick(ERR);
    rst = 0;
    tick(NONE);
    rst = 1;
    clear_inputs();
    tick(NONE);
    set_load_use(5'd2, 5'd2);
    tick(BUB);
    clear_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL timeout[%0d]: got %b want %b", n, o, e); end
      n++;
    end
    sel_to = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_store();
    test_mem_wait();
    test_deferred_redirect();
    test_branch_load_use();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
